// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - scheduler state encoding and array geometry defaults shared with the systolic array
package systolic_pkg;

    localparam int SA_N_SIZE     = 32;
    localparam int SA_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_WT   = 3'd1,
        WAIT_RDY  = 3'd2,
        STREAM    = 3'd3,
        DRAIN     = 3'd4,
        WAIT_DONE = 3'd5
    } sched_state_t;

endpackage

// File: rtl/systolic_tile_scheduler_if.sv
// rtl/systolic_tile_scheduler_if.sv - scheduler-to-systolic-array strobe, address and handshake bundle
interface systolic_tile_scheduler_if
    import systolic_pkg::*;
#(
    parameter int ADDR_WIDTH = SA_ADDR_WIDTH
);
    logic                  load_weight;
    logic                  valid_in;
    logic                  zero_a;
    logic                  first_iteration;
    logic                  last_tile;
    logic [ADDR_WIDTH-1:0] wt_addr;
    logic [ADDR_WIDTH-1:0] act_addr;
    logic                  sa_ready;
    logic                  sa_done;

    modport master (
        output load_weight, valid_in, zero_a, first_iteration, last_tile, wt_addr, act_addr,
        input  sa_ready, sa_done
    );

    modport slave (
        input  load_weight, valid_in, zero_a, first_iteration, last_tile, wt_addr, act_addr,
        output sa_ready, sa_done
    );
endinterface

// File: rtl/systolic_sched_addr_gen.sv
// rtl/systolic_sched_addr_gen.sv - phase row counter and per-K-tile base plus row address generation
module systolic_sched_addr_gen
    import systolic_pkg::*;
#(
    parameter int N_SIZE     = SA_N_SIZE,
    parameter int ADDR_WIDTH = SA_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_start,
    input  logic                  tile_adv,
    input  logic                  cnt_clr,
    input  logic                  cnt_inc,
    input  logic                  wt_en,
    input  logic                  act_en,
    input  logic [ADDR_WIDTH-1:0] rows,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    output logic [ADDR_WIDTH-1:0] act_addr
);
    logic [ADDR_WIDTH-1:0] wt_base;
    logic [ADDR_WIDTH-1:0] act_base;
    logic [ADDR_WIDTH-1:0] wt_base_nxt;
    logic [ADDR_WIDTH-1:0] act_base_nxt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    // Bases step by one weight block / one activation block per K tile, so no multiplier is needed
    always_comb begin
        wt_base_nxt  = wt_base;
        act_base_nxt = act_base;
        cnt_nxt      = cnt;
        if (job_start) begin
            wt_base_nxt  = '0;
            act_base_nxt = '0;
        end else if (tile_adv) begin
            wt_base_nxt  = wt_base + ADDR_WIDTH'(N_SIZE);
            act_base_nxt = act_base + rows;
        end
        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (cnt_inc) begin
            cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
    end

    // Addresses are registered from next-cycle base and row so they line up with the registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_base  <= '0;
            act_base <= '0;
            cnt      <= '0;
            wt_addr  <= '0;
            act_addr <= '0;
        end else begin
            wt_base  <= wt_base_nxt;
            act_base <= act_base_nxt;
            cnt      <= cnt_nxt;
            if (wt_en) begin
                wt_addr <= wt_base_nxt + cnt_nxt;
            end
            if (job_start) begin
                act_addr <= '0;
            end else if (act_en) begin
                act_addr <= act_base_nxt + cnt_nxt;
            end
        end
    end
endmodule

// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - K-tile job sequencer for the systolic array; SYSTOLIC_SCHED_PERF_EN enables perf_cycles
module systolic_tile_scheduler
    import systolic_pkg::*;
#(
    parameter int N_SIZE     = SA_N_SIZE,
    parameter int ADDR_WIDTH = SA_ADDR_WIDTH,
    parameter int KT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] cfg_rows,
    input  logic [KT_WIDTH-1:0]   cfg_k_tiles,
    systolic_tile_scheduler_if.master sa,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           perf_cycles
);
    localparam logic [ADDR_WIDTH-1:0] LW_LAST = ADDR_WIDTH'(N_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] DR_LAST = ADDR_WIDTH'((N_SIZE > 1) ? N_SIZE - 2 : 0);
    // A 1x1 array has nothing to drain
    localparam sched_state_t POST_STREAM = (N_SIZE > 1) ? DRAIN : WAIT_DONE;

    sched_state_t          state, state_d;
    logic [KT_WIDTH-1:0]   kt, kt_d, kt_last, kt_last_d;
    logic [ADDR_WIDTH-1:0] rows_r, rows_d, cnt;
    logic job_start, tile_adv, cnt_clr, cnt_inc, wt_en, act_en, done_d, err_d;
    logic load_weight_q, valid_in_q, zero_a_q, first_q, last_q;

    // Next state, tile bookkeeping and address-generator controls
    always_comb begin
        state_d   = state;
        kt_d      = kt;
        kt_last_d = kt_last;
        rows_d    = rows_r;
        job_start = 1'b0;
        tile_adv  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        wt_en     = 1'b0;
        act_en    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                if (cfg_rows != '0 && cfg_k_tiles != '0) begin
                    job_start = 1'b1;
                    rows_d    = cfg_rows;
                    kt_last_d = cfg_k_tiles - KT_WIDTH'(1);
                    kt_d      = '0;
                    cnt_clr   = 1'b1;
                    wt_en     = 1'b1;
                    state_d   = LOAD_WT;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                LOAD_WT: begin
                    if (cnt == LW_LAST) begin
                        state_d = WAIT_RDY;
                    end else begin
                        cnt_inc = 1'b1;
                        wt_en   = 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (sa.sa_ready) begin
                        state_d = STREAM;
                        cnt_clr = 1'b1;
                        act_en  = 1'b1;
                    end
                end
                STREAM: begin
                    if (cnt == rows_r - ADDR_WIDTH'(1)) begin
                        state_d = POST_STREAM;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        act_en  = 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == DR_LAST) begin
                        state_d = WAIT_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (sa.sa_done) begin
                        if (kt == kt_last) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            kt_d     = kt + KT_WIDTH'(1);
                            tile_adv = 1'b1;
                            cnt_clr  = 1'b1;
                            wt_en    = 1'b1;
                            state_d  = LOAD_WT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and outputs are registered from next-state values so strobes start the cycle the phase does
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            kt            <= '0;
            kt_last       <= '0;
            rows_r        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            load_weight_q <= 1'b0;
            valid_in_q    <= 1'b0;
            zero_a_q      <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state         <= state_d;
            kt            <= kt_d;
            kt_last       <= kt_last_d;
            rows_r        <= rows_d;
            busy          <= (state_d != IDLE);
            done          <= done_d;
            err           <= err_d;
            load_weight_q <= (state_d == LOAD_WT);
            valid_in_q    <= (state_d == STREAM) || (state_d == DRAIN);
            zero_a_q      <= (state_d == DRAIN);
            first_q       <= (state_d != IDLE) && (kt_d == '0);
            last_q        <= (state_d != IDLE) && (kt_d == kt_last_d);
        end
    end

    systolic_sched_addr_gen #(
        .N_SIZE     (N_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_start (job_start),
        .tile_adv  (tile_adv),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .wt_en     (wt_en),
        .act_en    (act_en),
        .rows      (rows_r),
        .cnt       (cnt),
        .wt_addr   (sa.wt_addr),
        .act_addr  (sa.act_addr)
    );

    assign sa.load_weight     = load_weight_q;
    assign sa.valid_in        = valid_in_q;
    assign sa.zero_a          = zero_a_q;
    assign sa.first_iteration = first_q;
    assign sa.last_tile       = last_q;

`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [31:0] perf_q;

    // Job cycle counter: cleared on accepted start, counts busy cycles, holds when idle, saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (job_start) begin
            perf_q <= '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb/tb_systolic_tile_scheduler.sv - vector table plus scoreboard bench for systolic_tile_scheduler
module tb_systolic_tile_scheduler;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int KW = 8;

    typedef struct {
        bit          lw;
        bit          vin;
        bit          za;
        bit          chk_addr;
        logic [AW-1:0] addr;
        bit          first;
        bit          last;
    } exp_t;

    typedef struct {
        int rows;
        int kts;
        bit exp_err;
        int dly;
        bit with_abort;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] cfg_rows = '0;
    logic [KW-1:0] cfg_k_tiles = '0;
    logic          busy, done, err;
    logic [31:0]   perf_cycles;
    logic          ready_drv = 1'b1;
    logic          resp_done = 1'b0;
    logic          stray_done = 1'b0;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   busy_total = 0;
    int   done_delay = 0;
    int   resp_wait = 0;
    bit   resp_pend = 0;
    bit   vin_prev = 0;

    systolic_tile_scheduler_if #(.ADDR_WIDTH(AW)) sa ();
    assign sa.sa_ready = ready_drv;
    assign sa.sa_done  = resp_done | stray_done;

    systolic_tile_scheduler #(
        .N_SIZE     (N),
        .ADDR_WIDTH (AW),
        .KT_WIDTH   (KW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_rows    (cfg_rows),
        .cfg_k_tiles (cfg_k_tiles),
        .sa          (sa),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Negedge observer: scoreboard pop/compare, done/busy tallies, sa_done responder
    task automatic sample();
        exp_t e;
        logic [14:0] got_v, exp_v;
        if (!rst_n) begin
            vin_prev  = 0;
            resp_pend = 0;
            resp_done = 1'b0;
            return;
        end
        if (busy) busy_total++;
        if (done) done_cnt++;
        if (sa.load_weight || sa.valid_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {62'd0, sa.load_weight, sa.valid_in}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                got_v = {sa.load_weight, sa.valid_in, sa.zero_a, sa.first_iteration, sa.last_tile,
                         e.chk_addr ? (e.lw ? sa.wt_addr : sa.act_addr) : {AW{1'b0}}};
                exp_v = {e.lw, e.vin, e.za, e.first, e.last, e.chk_addr ? e.addr : {AW{1'b0}}};
                check("strobe_record", {49'd0, got_v}, {49'd0, exp_v});
            end
        end
        resp_done = 1'b0;
        if (vin_prev && !sa.valid_in) begin
            resp_pend = 1;
            resp_wait = done_delay;
        end
        if (resp_pend) begin
            if (resp_wait == 0) begin
                resp_done = 1'b1;
                resp_pend = 0;
            end else begin
                resp_wait--;
            end
        end
        vin_prev = sa.valid_in;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input int rows, input int kt, input int kts, input int n_str, input bit drain);
        exp_t e;
        e.first = (kt == 0);
        e.last  = (kt == kts - 1);
        for (int r = 0; r < N; r++) begin
            e.lw = 1; e.vin = 0; e.za = 0; e.chk_addr = 1; e.addr = AW'(kt * N + r);
            exp_q.push_back(e);
        end
        for (int r = 0; r < n_str; r++) begin
            e.lw = 0; e.vin = 1; e.za = 0; e.chk_addr = 1; e.addr = AW'(kt * rows + r);
            exp_q.push_back(e);
        end
        if (drain) begin
            for (int r = 0; r < N - 1; r++) begin
                e.lw = 0; e.vin = 1; e.za = 1; e.chk_addr = 0; e.addr = '0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_job(input int rows, input int kts);
        for (int kt = 0; kt < kts; kt++) push_tile(rows, kt, kts, rows, 1);
    endtask

    task automatic finish_job(input int d0, input int b0);
        for (int i = 0; i < 6000 && done_cnt == d0; i++) tick();
        check("done_seen", done_cnt, d0 + 1);
        repeat (3) tick();
        check("single_done", done_cnt, d0 + 1);
        check("idle_flags", {59'd0, busy, sa.first_iteration, sa.last_tile, sa.load_weight, sa.valid_in}, 64'd0);
        check("queue_drained", exp_q.size(), 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
        check("perf_cycles", perf_cycles, busy_total - b0);
`else
        check("perf_zero", perf_cycles, 0);
`endif
    endtask

    task automatic run_valid(input int rows, input int kts, input bit with_abort);
        int d0, b0;
        push_job(rows, kts);
        d0 = done_cnt;
        b0 = busy_total;
        cfg_rows = AW'(rows);
        cfg_k_tiles = KW'(kts);
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_accept", {52'd0, busy, sa.load_weight, sa.wt_addr}, {52'd0, 2'b11, {AW{1'b0}}});
        finish_job(d0, b0);
    endtask

    initial begin
        int d0, b0;
        bit bad;
        vecs[0] = '{rows: 3,   kts: 1,   exp_err: 0, dly: 0, with_abort: 0};
        vecs[1] = '{rows: 2,   kts: 3,   exp_err: 0, dly: 2, with_abort: 0};
        vecs[2] = '{rows: 0,   kts: 2,   exp_err: 1, dly: 0, with_abort: 0};
        vecs[3] = '{rows: 5,   kts: 0,   exp_err: 1, dly: 0, with_abort: 0};
        vecs[4] = '{rows: 1,   kts: 2,   exp_err: 0, dly: 1, with_abort: 1};
        vecs[5] = '{rows: 700, kts: 2,   exp_err: 0, dly: 0, with_abort: 0};
        vecs[6] = '{rows: 1,   kts: 255, exp_err: 0, dly: 0, with_abort: 0};

        repeat (2) tick();
        check("reset_state", {busy, done, err, sa.load_weight, sa.valid_in, sa.zero_a, sa.first_iteration,
                              sa.last_tile, sa.wt_addr, sa.act_addr, perf_cycles}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            done_delay = vecs[v].dly;
            if (vecs[v].exp_err) begin
                d0 = done_cnt;
                cfg_rows = AW'(vecs[v].rows);
                cfg_k_tiles = KW'(vecs[v].kts);
                start = 1'b1;
                tick();
                start = 1'b0;
                check("err_pulse", {61'd0, err, busy, sa.load_weight}, 64'd4);
                tick();
                check("err_clear", {61'd0, err, busy, sa.load_weight}, 64'd0);
                repeat (3) tick();
                check("err_no_done", done_cnt, d0);
            end else begin
                run_valid(vecs[v].rows, vecs[v].kts, vecs[v].with_abort);
            end
        end

        // Abort during the stream phase of K tile 1, then a fresh job restarts at tile 0
        done_delay = 0;
        push_tile(2, 0, 3, 2, 1);
        push_tile(2, 1, 3, 2, 0);
        d0 = done_cnt;
        cfg_rows = AW'(2);
        cfg_k_tiles = KW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 1; i++) tick();
        check("abort_reach_stream", exp_q.size(), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {60'd0, busy, sa.valid_in, sa.load_weight, sa.zero_a}, 64'd0);
        repeat (10) tick();
        check("abort_no_done", done_cnt, d0);
        check("abort_queue", exp_q.size(), 0);
        run_valid(2, 1, 0);

        // sa_ready held low, start/config change while busy, stray sa_done while streaming
        ready_drv = 1'b0;
        push_job(3, 1);
        d0 = done_cnt;
        b0 = busy_total;
        cfg_rows = AW'(3);
        cfg_k_tiles = KW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                start = 1'b1;
                cfg_rows = AW'(7);
                cfg_k_tiles = KW'(5);
            end
            tick();
            start = 1'b0;
            if (sa.valid_in) bad = 1;
        end
        check("hold_no_valid", bad, 0);
        check("hold_busy", busy, 1);
        ready_drv = 1'b1;
        for (int i = 0; i < 20 && !sa.valid_in; i++) tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        finish_job(d0, b0);

        // Asynchronous reset mid-job discards it
        push_job(2, 1);
        cfg_rows = AW'(2);
        cfg_k_tiles = KW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", {busy, done, err, sa.load_weight, sa.valid_in, sa.zero_a, sa.first_iteration,
                              sa.last_tile, sa.wt_addr, sa.act_addr, perf_cycles}, 64'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("reset_no_done", {31'd0, busy, 32'(done_cnt - d0)}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/systolic_tile_scheduler.md
SYSTOLIC_TILE_SCHEDULER -- requirements
Module: systolic_tile_scheduler

Interface
- REQ-001: Parameter N_SIZE, default 32: systolic array dimension (rows/cols).
- REQ-002: Parameter ADDR_WIDTH, default 10: activation/weight buffer address width.
- REQ-003: Parameter KT_WIDTH, default 8: width of K-tile count.
- REQ-004: clk, input, 1: single clock; all logic rising-edge.
- REQ-005: rst_n, input, 1: asynchronous active-low reset.
- REQ-006: start, input, 1: one-cycle job request.
- REQ-007: abort, input, 1: cancel running job.
- REQ-008: cfg_rows, input, ADDR_WIDTH: activation rows (M) per K tile.
- REQ-009: cfg_k_tiles, input, KT_WIDTH: number of K tiles to accumulate.
- REQ-010: sa_ready, input, 1: systolic array ready for a pass.
- REQ-011: sa_done, input, 1: systolic array pass complete (one-cycle pulse).
- REQ-012: load_weight, output, 1: weight-row load strobe to the array.
- REQ-013: valid_in, output, 1: activation/drain data valid.
- REQ-014: zero_a, output, 1: fetch logic substitutes zero activations (drain).
- REQ-015: first_iteration, output, 1: current tile is K tile 0 (no partial sums).
- REQ-016: last_tile, output, 1: current tile is final K tile.
- REQ-017: wt_addr, output, ADDR_WIDTH: weight buffer read address.
- REQ-018: act_addr, output, ADDR_WIDTH: activation buffer read address.
- REQ-019: busy, output, 1: job in progress; done, output, 1: job-complete pulse; err, output, 1: bad-config pulse.
- REQ-020: perf_cycles, output, 32: job cycle count (see Configuration).

Function
- REQ-021: States IDLE, LOAD_WT, WAIT_RDY, STREAM, DRAIN, WAIT_DONE; encoding in package.
- REQ-022: IDLE: start with cfg_rows!=0 and cfg_k_tiles!=0 latches config, clears tile counter kt and act_addr, sets busy, goes LOAD_WT next cycle.
- REQ-023: IDLE: start with cfg_rows==0 or cfg_k_tiles==0 pulses err one cycle, stays IDLE, busy stays 0.
- REQ-024: LOAD_WT: load_weight=1 for exactly N_SIZE cycles; wt_addr = kt*N_SIZE + row, row 0..N_SIZE-1; then WAIT_RDY.
- REQ-025: WAIT_RDY: all strobes low; on sa_ready=1 go STREAM.
- REQ-026: STREAM: valid_in=1 for exactly cfg_rows cycles; act_addr = kt*cfg_rows + r, r incrementing; then DRAIN.
- REQ-027: DRAIN: valid_in=1, zero_a=1 for exactly N_SIZE-1 cycles; then WAIT_DONE.
- REQ-028: WAIT_DONE: on sa_done: if kt==cfg_k_tiles-1 pulse done one cycle, clear busy, go IDLE; else kt++, go LOAD_WT.
- REQ-029: first_iteration = (kt==0), last_tile = (kt==cfg_k_tiles-1), both registered, valid whenever busy, 0 in IDLE.
- REQ-030: sa_done outside WAIT_DONE ignored; start while busy ignored; config changes while busy ignored.
- REQ-031: abort (any busy state) returns to IDLE next cycle, all strobes low, busy=0, no done pulse; abort and start same cycle in IDLE: start wins.
- REQ-032: Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow flag.
- REQ-033: All outputs registered; first load_weight one cycle after accepted start.

Reset
- REQ-034: rst_n low asynchronously forces IDLE, kt=0, all addresses 0, all outputs 0 (incl. perf_cycles); reset mid-job discards job, no done.

Configuration
- REQ-035: Macro SYSTOLIC_SCHED_PERF_EN defined: perf_cycles clears on accepted start, increments each busy cycle, holds after done/abort until next start, saturates at 2^32-1.
- REQ-036: Macro undefined: perf_cycles tied to 0, no counter logic.

Structure
- REQ-037: Package systolic_pkg holds state enum sched_state_t and default N_SIZE/ADDR_WIDTH constants shared with the array.
- REQ-038: One sub-module systolic_sched_addr_gen (row counter + base-address add for wt_addr/act_addr).

Verification
- REQ-039: N=4, rows=3, k_tiles=1: load_weight 4 cycles (wt_addr 0..3), valid_in 3 cycles (act_addr 0..2), zero_a 3 cycles, first_iteration=last_tile=1, done after sa_done.
- REQ-040: rows=2, k_tiles=3, N=4: wt_addr bases 0,4,8; act_addr bases 0,2,4; first_iteration only kt=0; last_tile only kt=2; one done.
- REQ-041: start with rows=0 -> err pulse 1 cycle, busy=0, no load_weight.
- REQ-042: abort during STREAM of kt=1 -> IDLE next cycle, valid_in=0, no done; new start runs from kt=0.
- REQ-043: sa_ready held low 10 cycles in WAIT_RDY -> no valid_in until sa_ready; stray sa_done in STREAM ignored.
- REQ-044: With SYSTOLIC_SCHED_PERF_EN, N=4, rows=3, k_tiles=1, sa_ready/sa_done immediate -> perf_cycles equals measured busy cycles; without macro perf_cycles=0.
